dll_code_update_seq: RTL
========================

# dll_code_update_seq

Responder side of the DLL code-update request raised by the DLL delay monitor. It accepts a `code_update` request and waits for a controller refresh/idle window. It then runs the DFI controller-update handshake with the PHY, pulses the DLL load, waits for settle and lock, and releases the PHY. It sits in the COREDDR_TIP training/monitor path, in the `SCLK` domain, between the monitor and the NWL PHY DFI update interface.

## Interface
- `ACK_TIMEOUT`, 64: max cycles in REQ waiting for `dfi_ctrlupd_ack`; valid range 1..1023.
- `LOAD_WIDTH`, 2: `dll_load` high time in cycles; valid range 1..1023.
- `SETTLE_CYCLES`, 16: minimum cycles after load before `dll_lock` is sampled; valid range 1..1023.
- `LOCK_TIMEOUT`, 256: max cycles in SETTLE, counted from SETTLE entry; must be > `SETTLE_CYCLES`.
- `SCLK`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `code_update`  in  1  level request from the monitor; held until `update_done` or `update_err`.
- `refresh_window`  in  1  controller indicates a refresh/idle slot; sampled only in WAIT_WIN.
- `dfi_ctrlupd_req`  out  1  DFI controller-update request to the PHY.
- `dfi_ctrlupd_ack`  in  1  PHY acknowledge.
- `dll_load`  out  1  DLL code load strobe.
- `dll_lock`  in  1  DLL lock status, synchronous to `SCLK`.
- `update_busy`  out  1  high in any state except IDLE.
- `update_done`  out  1  one-cycle pulse on successful completion.
- `update_err`  out  1  one-cycle pulse on ack timeout or lock timeout.

## Operation
- FSM states: IDLE, WAIT_WIN, REQ, LOAD, SETTLE, RELEASE. All outputs are registered.
- IDLE: `code_update`=1 -> WAIT_WIN.
- WAIT_WIN: `refresh_window`=1 -> REQ and `dfi_ctrlupd_req` is set. If `code_update` drops, return to IDLE with no pulse.
- REQ: `dfi_ctrlupd_req` is held high.
  - `dfi_ctrlupd_ack`=1 -> LOAD.
  - If the counter reaches `ACK_TIMEOUT` with no ack: clear req, pulse `update_err`, go to IDLE.
  - After an error, a `code_update` that is still high retries from WAIT_WIN on the next cycle.
- LOAD: `dll_load`=1 for exactly `LOAD_WIDTH` cycles, then SETTLE.
- SETTLE: the counter runs from 0.
  - Once count ≥ `SETTLE_CYCLES` and `dll_lock`=1 -> RELEASE.
  - At count = `LOCK_TIMEOUT`: go to RELEASE with the error flag set.
- RELEASE: clear `dfi_ctrlupd_req` and wait for `dfi_ctrlupd_ack`=0.
  - Then go to IDLE and pulse `update_done`, or `update_err` if the error flag is set. Never both.
- Ack dropping early (before RELEASE) is ignored. Req stays high until RELEASE.
- Single shared counter, width clog2(max parameter)+1. It clears on every state entry and saturates; it never wraps.
- When IDLE is entered, `code_update` is not sampled in the same cycle. The next request is taken from the following cycle.

## Timing
- Reset values: state IDLE, counter 0, error flag 0. `dfi_ctrlupd_req`, `dll_load`, `update_busy`, `update_done`, `update_err` are all 0.
- Reset asserted mid-sequence: all outputs drop to 0 asynchronously; `dfi_ctrlupd_req` is dropped without waiting for ack.
- `code_update` sampled at edge N -> `update_busy`=1 from N+1.
- `refresh_window` at edge N in WAIT_WIN -> `dfi_ctrlupd_req`=1 from N+1.
- Ack at edge N in REQ -> `dll_load`=1 from N+1 for `LOAD_WIDTH` cycles.
- Minimum request-to-done with window, ack and lock already present:
  - 1 (IDLE) + 1 (WAIT_WIN) + 1 (REQ) + `LOAD_WIDTH` + `SETTLE_CYCLES` + 1 (RELEASE) + 1 (done pulse) cycles.
- `refresh_window` and an ack timeout in the same cycle cannot occur, since they are sampled in different states.

## Structure
- Shared package `ddr_tip_pkg`: state enum `dll_upd_state_t` and default timeout constants.
- One natural sub-module, `dll_upd_timer`: loadable saturating counter with a terminal-count compare. It serves ACK, LOAD, SETTLE and LOCK timing.
- Top level contains the FSM, the error flag and the output registers.

## Test plan
- Nominal (defaults; window 3 cycles after request; ack 2 cycles after req; lock already high):
  - `dll_load` is exactly 2 cycles and req drops once SETTLE completes.
  - A single `update_done`; `update_busy` falls in the same cycle as the done pulse.
- Ack never arrives:
  - `update_err` pulses at REQ entry + 64 and req drops.
  - With `code_update` still high, req reasserts on the next `refresh_window`.
- `dll_lock` held low:
  - Exit to RELEASE at SETTLE entry + 256.
  - `update_err` pulses after ack falls, with no `update_done`.
- `code_update` deasserted in WAIT_WIN before any window: return to IDLE; req, load, done and err never assert.
- Reset asserted two cycles into LOAD:
  - All outputs are 0 immediately.
  - After release, a fresh `code_update` completes a full nominal sequence.
- Ack held high for 5 cycles after req drops: `update_done` fires exactly 1 cycle after ack falls.

Source files
------------

// File: rtl/ddr_tip_pkg.sv
// Shared types and defaults for the DDR training/monitor (TIP) blocks.
package ddr_tip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_WIN = 3'd1,
    ST_REQ      = 3'd2,
    ST_LOAD     = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_RELEASE  = 3'd5
  } dll_upd_state_t;

  localparam int DEF_ACK_TIMEOUT   = 64;
  localparam int DEF_LOAD_WIDTH    = 2;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT  = 256;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dll_upd_timer.sv
// Shared phase timer: cleared on every state entry, counts up and holds at
// all-ones. o_tc flags the cycle that completes i_limit cycles in the state,
// so a transition taken on o_tc leaves exactly i_limit cycles spent there.
module dll_upd_timer #(
  parameter int CNT_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last  = i_limit - CNT_W'(1);
  assign o_tc    = (r_count >= w_last);
  assign o_count = r_count;

  // count cycles since the last clear, never wrapping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dll_code_update_seq.sv
// DLL code-update responder: waits for a refresh window, runs the DFI
// ctrlupd handshake, strobes the DLL load, waits for settle/lock, releases.
//
// state    | meaning
// IDLE     | no request in progress
// WAIT_WIN | request seen, waiting for a controller refresh/idle slot
// REQ      | ctrlupd_req high, waiting for PHY ack (bounded)
// LOAD     | dll_load strobe high for LOAD_WIDTH cycles
// SETTLE   | waiting minimum settle time then dll_lock (bounded)
// RELEASE  | req dropped, waiting for ack low before reporting
module dll_code_update_seq
  import ddr_tip_pkg::*;
#(
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
  parameter int LOAD_WIDTH    = DEF_LOAD_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
  input  logic i_sclk,
  input  logic i_reset,
  input  logic i_code_update,
  input  logic i_refresh_window,
  output logic o_dfi_ctrlupd_req,
  input  logic i_dfi_ctrlupd_ack,
  output logic o_dll_load,
  input  logic i_dll_lock,
  output logic o_update_busy,
  output logic o_update_done,
  output logic o_update_err
);

  localparam int CNT_MAX = max_of4(ACK_TIMEOUT, LOAD_WIDTH, SETTLE_CYCLES, LOCK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  dll_upd_state_t   r_state;
  dll_upd_state_t   w_next_state;
  logic             r_err;
  logic             w_err_next;
  logic             w_clear;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
  logic             w_settled;
  logic             w_req_d;
  logic             w_load_d;
  logic             w_busy_d;
  logic             w_done_d;
  logic             w_uerr_d;

  // restart the timer whenever the state changes
  assign w_clear   = (w_next_state != r_state);
  assign w_settled = (w_count >= CNT_W'(SETTLE_CYCLES - 1));

  // terminal count follows whichever bound the current state uses
  always_comb begin
    w_limit = CNT_W'(ACK_TIMEOUT);
    case (r_state)
      ST_LOAD:   w_limit = CNT_W'(LOAD_WIDTH);
      ST_SETTLE: w_limit = CNT_W'(LOCK_TIMEOUT);
      default:   w_limit = CNT_W'(ACK_TIMEOUT);
    endcase
  end

  dll_upd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk   (i_sclk),
    .i_rst   (i_reset),
    .i_clear (w_clear),
    .i_limit (w_limit),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // state, error flag and registered outputs
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= ST_IDLE;
      r_err             <= 1'b0;
      o_dfi_ctrlupd_req <= 1'b0;
      o_dll_load        <= 1'b0;
      o_update_busy     <= 1'b0;
      o_update_done     <= 1'b0;
      o_update_err      <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_err             <= w_err_next;
      o_dfi_ctrlupd_req <= w_req_d;
      o_dll_load        <= w_load_d;
      o_update_busy     <= w_busy_d;
      o_update_done     <= w_done_d;
      o_update_err      <= w_uerr_d;
    end
  end

  // transitions; ack wins over the ack timeout, lock wins over the lock timeout
  always_comb begin
    w_next_state = r_state;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        w_err_next = 1'b0;
        if (i_code_update) w_next_state = ST_WAIT_WIN;
      end
      ST_WAIT_WIN: begin
        if (!i_code_update)        w_next_state = ST_IDLE;
        else if (i_refresh_window) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        if (i_dfi_ctrlupd_ack) w_next_state = ST_LOAD;
        else if (w_tc)         w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_tc) w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_settled && i_dll_lock) begin
          w_next_state = ST_RELEASE;
        end else if (w_tc) begin
          w_next_state = ST_RELEASE;
          w_err_next   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!i_dfi_ctrlupd_ack) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_err_next   = 1'b0;
      end
    endcase
  end

  // next output values, decoded from the transition being taken
  always_comb begin
    w_req_d  = (w_next_state == ST_REQ) || (w_next_state == ST_LOAD) ||
               (w_next_state == ST_SETTLE);
    w_load_d = (w_next_state == ST_LOAD);
    w_busy_d = (w_next_state != ST_IDLE);
    w_done_d = (r_state == ST_RELEASE) && (w_next_state == ST_IDLE) && !r_err;
    w_uerr_d = ((r_state == ST_REQ) && (w_next_state == ST_IDLE)) ||
               ((r_state == ST_RELEASE) && (w_next_state == ST_IDLE) && r_err);
  end

endmodule
